// File: rtl/alu_input_loader.sv
// -----------------------------------------------------------------------------
// alu_input_loader
//
// Operand/opcode capture stage sitting directly in front of the ALU. A shared
// switch bus is latched into one of three holding registers (operand A,
// operand B, op code). Each register has its own push-button. Every button is
// synchronised, debounced and rising-edge detected before it triggers a load.
//
// Ports:
//   i_clk      system clock, rising edge
//   i_rst_n    asynchronous active-low reset
//   i_sw       switch bus, quasi-static, sampled directly in the load cycle
//   i_btn      raw buttons: [0] load A, [1] load B, [2] load op code
//   o_data_a   operand A to the ALU
//   o_data_b   operand B to the ALU
//   o_code     op code to the ALU
//   o_loaded   per-register "loaded since reset" flags (same order as i_btn)
//   o_ready    all three registers have been loaded
//   o_strobe   one-cycle pulse in the first cycle new data is on the outputs
// -----------------------------------------------------------------------------
module alu_input_loader #(
  parameter int NB_DATA    = 8,
  parameter int NB_OP      = 6,
  parameter int NB_SW      = 8,
  parameter int DB_CNT_MAX = 16
) (
  input  logic               i_clk,
  input  logic               i_rst_n,
  input  logic [NB_SW-1:0]   i_sw,
  input  logic [2:0]         i_btn,
  output logic [NB_DATA-1:0] o_data_a,
  output logic [NB_DATA-1:0] o_data_b,
  output logic [NB_OP-1:0]   o_code,
  output logic [2:0]         o_loaded,
  output logic               o_ready,
  output logic               o_strobe
);

  // Counter is wide enough to hold DB_CNT_MAX; the flip happens on the cycle
  // the count would reach it, i.e. when the current count is DB_CNT_MAX-1.
  localparam int              CNT_W    = $clog2(DB_CNT_MAX + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DB_CNT_MAX - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  logic [2:0] load_pulse;

  // ---------------------------------------------------------------------------
  // Per-button conditioning: 2-flop synchroniser, debounce counter, edge pulse
  // ---------------------------------------------------------------------------
  generate
    for (genvar gi = 0; gi < 3; gi++) begin : g_btn
      logic             sync1_q;
      logic             sync2_q;
      logic             db_q;
      logic             db_d;
      logic             db_prev_q;
      logic             pulse_q;
      logic             pulse_d;
      logic [CNT_W-1:0] cnt_q;
      logic [CNT_W-1:0] cnt_d;

      always_comb begin
        db_d  = db_q;
        cnt_d = '0;
        // Any cycle where the synchronised level agrees with the debounced
        // level clears the count, so a short glitch never accumulates.
        if (sync2_q != db_q) begin
          if (cnt_q == CNT_LAST) begin
            db_d  = sync2_q;
            cnt_d = '0;
          end else begin
            cnt_d = cnt_q + CNT_ONE;
          end
        end
        // Rising edge of the debounced level only; releases are ignored.
        pulse_d = db_q & ~db_prev_q;
      end

      always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
          sync1_q   <= 1'b0;
          sync2_q   <= 1'b0;
          db_q      <= 1'b0;
          db_prev_q <= 1'b0;
          cnt_q     <= '0;
          pulse_q   <= 1'b0;
        end else begin
          sync1_q   <= i_btn[gi];
          sync2_q   <= sync1_q;
          db_q      <= db_d;
          db_prev_q <= db_q;
          cnt_q     <= cnt_d;
          pulse_q   <= pulse_d;
        end
      end

      assign load_pulse[gi] = pulse_q;
    end
  endgenerate

  // ---------------------------------------------------------------------------
  // Holding registers
  // ---------------------------------------------------------------------------
  logic [NB_DATA-1:0] data_a_q, data_a_d;
  logic [NB_DATA-1:0] data_b_q, data_b_d;
  logic [NB_OP-1:0]   code_q,   code_d;
  logic [2:0]         loaded_q, loaded_d;
  logic               strobe_q, strobe_d;

  always_comb begin
    data_a_d = data_a_q;
    data_b_d = data_b_q;
    code_d   = code_q;
    if (load_pulse[0]) data_a_d = i_sw[NB_DATA-1:0];
    if (load_pulse[1]) data_b_d = i_sw[NB_DATA-1:0];
    if (load_pulse[2]) code_d   = i_sw[NB_OP-1:0];
    loaded_d = loaded_q | load_pulse;
    // Coincident loads share a single strobe cycle.
    strobe_d = |load_pulse;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      data_a_q <= '0;
      data_b_q <= '0;
      code_q   <= '0;
      loaded_q <= '0;
      strobe_q <= 1'b0;
    end else begin
      data_a_q <= data_a_d;
      data_b_q <= data_b_d;
      code_q   <= code_d;
      loaded_q <= loaded_d;
      strobe_q <= strobe_d;
    end
  end

  assign o_data_a = data_a_q;
  assign o_data_b = data_b_q;
  assign o_code   = code_q;
  assign o_loaded = loaded_q;
  assign o_ready  = &loaded_q;
  assign o_strobe = strobe_q;

endmodule
